// File: rtl/mlam_rgb_sched.sv
// rtl/mlam_rgb_sched.sv - sequences one shared 8x8 multiplier over R, G, B to square each pixel channel
module mlam_rgb_sched #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int ROUND  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [16:1] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        out_last
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MR,
        S_MG,
        S_MB,
        S_OUT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] pixel_cnt_q;
    logic [7:0]    g_q;
    logic [7:0]    b_q;
    logic [7:0]    mul_op_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [7:0]    out_r_q;
    logic [7:0]    out_g_q;
    logic [7:0]    out_b_q;
    logic [7:0]    scaled_d;
    logic [8:0]    rounded_d;

    // Rounding adds bit 8 into the kept byte; a carry out means saturate.
    always_comb begin
        rounded_d = {1'b0, mul_p[16:9]} + {8'h00, mul_p[8]};
        if (ROUND == 0) begin
            scaled_d = mul_p[16:9];
        end else if (rounded_d[8]) begin
            scaled_d = 8'hFF;
        end else begin
            scaled_d = rounded_d[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pixel_cnt_q <= '0;
            g_q         <= 8'h00;
            b_q         <= 8'h00;
            mul_op_q    <= 8'h00;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= 8'h00;
            out_g_q     <= 8'h00;
            out_b_q     <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mul_op_q   <= in_r;
                        g_q        <= in_g;
                        b_q        <= in_b;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MR;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                // Operands are registered one state ahead so each M state sees its own channel.
                S_MR: begin
                    out_r_q  <= scaled_d;
                    mul_op_q <= g_q;
                    state_q  <= S_MG;
                end
                S_MG: begin
                    out_g_q  <= scaled_d;
                    mul_op_q <= b_q;
                    state_q  <= S_MB;
                end
                S_MB: begin
                    out_b_q     <= scaled_d;
                    mul_op_q    <= 8'h00;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (pixel_cnt_q == LAST_CNT);
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        pixel_cnt_q <= (pixel_cnt_q == LAST_CNT) ? '0 : pixel_cnt_q + 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    mul_op_q    <= 8'h00;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_a     = mul_op_q;
    assign mul_b     = mul_op_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_r     = out_r_q;
    assign out_g     = out_g_q;
    assign out_b     = out_b_q;

endmodule

// File: tb/tb_mlam_rgb_sched.sv
// tb/tb_mlam_rgb_sched.sv - scoreboard bench for mlam_rgb_sched, truncating and rounding builds side by side
module tb_mlam_rgb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_r, in_g, in_b;
    logic        force_p;

    logic        in_ready0, in_ready1;
    logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
    logic [16:1] mul_p0, mul_p1;
    logic        ov0, ov1, ol0, ol1;
    logic [7:0]  or0, og0, ob0, or1, og1, ob1;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt = 0;
    logic [24:0] q0[$];
    logic [24:0] q1[$];
    logic [71:0] vec[9];

    always #5 clk = ~clk;

    assign mul_p0 = force_p ? 16'hFF80 : ({8'h00, mul_a0} * {8'h00, mul_b0});
    assign mul_p1 = force_p ? 16'hFF80 : ({8'h00, mul_a1} * {8'h00, mul_b1});

    mlam_rgb_sched #(.WIDTH(4), .HEIGHT(2), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
        .out_valid(ov0), .out_ready(out_ready),
        .out_r(or0), .out_g(og0), .out_b(ob0), .out_last(ol0)
    );

    mlam_rgb_sched #(.WIDTH(4), .HEIGHT(2), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
        .out_valid(ov1), .out_ready(out_ready),
        .out_r(or1), .out_g(og1), .out_b(ob1), .out_last(ol1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [23:0] e0, input logic [23:0] e1);
        logic last;
        last = (model_cnt == 7);
        q0.push_back({last, e0});
        q1.push_back({last, e1});
        model_cnt = (model_cnt + 1) % 8;
    endtask

    task automatic pop_cmp0();
        logic [24:0] e;
        if (q0.size() == 0) begin
            check("out0_unexpected", 32'({ol0, or0, og0, ob0}), 32'hFFFF_FFFF);
        end else begin
            e = q0.pop_front();
            check("out0", 32'({ol0, or0, og0, ob0}), 32'(e));
        end
    endtask

    task automatic pop_cmp1();
        logic [24:0] e;
        if (q1.size() == 0) begin
            check("out1_unexpected", 32'({ol1, or1, og1, ob1}), 32'hFFFF_FFFF);
        end else begin
            e = q1.pop_front();
            check("out1", 32'({ol1, or1, og1, ob1}), 32'(e));
        end
    endtask

    // Monitors: a handshake is what the edge after this negedge will see.
    always @(negedge clk) if (!rst && ov0 && out_ready) pop_cmp0();
    always @(negedge clk) if (!rst && ov1 && out_ready) pop_cmp1();

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_r = r;
        in_g = g;
        in_b = b;
        t = 0;
        while (!in_ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("accept_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int lowcnt, output int vlat);
        lowcnt = 0;
        vlat = 0;
        @(negedge clk);
        while (!in_ready0 && lowcnt < 20) begin
            lowcnt++;
            if (ov0 && vlat == 0) vlat = lowcnt;
            @(negedge clk);
        end
        if (lowcnt >= 20) check("idle_timeout", 32'(lowcnt), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lc, vl, t;
        // {r, g, b, truncated r/g/b, rounded r/g/b}
        vec[0] = 72'h80FF00_40FE00_40FE00;
        vec[1] = 72'h0C0C0C_000000_010101;
        vec[2] = 72'h101010_010101_010101;
        vec[3] = 72'hB50F20_7F0004_800104;
        vec[4] = 72'hC07FFE_903FFC_903FFC;
        vec[5] = 72'h0B1201_000100_000100;
        vec[6] = 72'hFFB50C_FE7F00_FE8001;
        vec[7] = 72'h20C00F_049000_049001;
        vec[8] = 72'h01FE10_00FC01_00FC01;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        force_p = 1'b0;
        in_r = 8'h00;
        in_g = 8'h00;
        in_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready0), 32'd0);
        check("rst_outs", 32'({ov0, ol0, or0, og0, ob0}), 32'd0);
        check("rst_mul", 32'({mul_a0, mul_b0}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(in_ready0), 32'd1);

        // Nine pixels over a frame of eight: last flag on the eighth only.
        for (int i = 0; i < 9; i++) begin
            push_exp(vec[i][47:24], vec[i][23:0]);
            send_pixel(vec[i][71:64], vec[i][63:56], vec[i][55:48]);
            wait_idle(lc, vl);
            if (i == 0) begin
                check("busy_cycles", 32'(lc), 32'd4);
                check("valid_latency", 32'(vl), 32'd4);
            end
        end

        // Back-pressure with a new pixel already offered.
        out_ready = 1'b0;
        push_exp(24'h903FFC, 24'h903FFC);
        send_pixel(8'hC0, 8'h7F, 8'hFE);
        t = 0;
        while (!ov0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("hold_reach_out", 32'(ov0), 32'd1);
        push_exp(24'h000100, 24'h000100);
        in_valid = 1'b1;
        in_r = 8'h0B;
        in_g = 8'h12;
        in_b = 8'h01;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_valid", 32'({ov0, ov1}), 32'd3);
            check("hold_data0", 32'({or0, og0, ob0}), 32'h903FFC);
            check("hold_data1", 32'({or1, og1, ob1}), 32'h903FFC);
            check("hold_in_ready", 32'({in_ready0, in_ready1}), 32'd0);
            check("hold_mul_quiet", 32'({mul_a0, mul_b0}), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_pixel(8'h0B, 8'h12, 8'h01);
        wait_idle(lc, vl);

        // Forced product saturates every channel in both builds.
        force_p = 1'b1;
        push_exp(24'hFFFFFF, 24'hFFFFFF);
        send_pixel(8'h12, 8'h34, 8'h56);
        wait_idle(lc, vl);
        force_p = 1'b0;

        // Reset while green is in the multiplier discards the pixel.
        send_pixel(8'h80, 8'h80, 8'h80);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("mid_red_captured", 32'(or0), 32'h40);
        rst = 1'b1;
        #1;
        check("midrst_outs", 32'({ov0, ol0, or0, og0, ob0}), 32'd0);
        check("midrst_in_ready", 32'(in_ready0), 32'd0);
        check("midrst_mul", 32'({mul_a0, mul_b0}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        @(posedge clk);
        #1;
        push_exp(24'h010101, 24'h010101);
        send_pixel(8'h10, 8'h10, 8'h10);
        wait_idle(lc, vl);

        repeat (5) @(posedge clk);
        #1;
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
